mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single main-memory port between the instruction cache (IC)
//   and the data cache (DC).
//
//   Each transaction runs arbitrate -> issue -> wait -> respond, and only
//   one transaction is in flight at a time. By default DC always beats IC
//   when both ask in the same cycle.
//
//   Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break ties by
//   alternating ports. A 1-bit last-owner register, which resets to IC,
//   decides the tie, so DC wins the first tie after reset.
//
// Ports
//   clk, reset      rising-edge clock; synchronous active-high reset
//   ic_req_*        IC line-fill request (read only)
//   ic_grant        IC owns the memory port (registered)
//   ic_resp_*       one-cycle fill-data pulse towards IC
//   dc_req_*        DC fill (rw=0) or write-back (rw=1) request
//   dc_grant        DC owns the memory port (registered)
//   dc_resp_*       one-cycle fill-data or write-ack pulse towards DC
//                   (data is 0 on a write ack)
//   mem_req_*       request towards memory, driven from latched fields
//   mem_req_ready   memory accepts the request this cycle
//   mem_resp_*      memory read data or write ack
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_grant,
  output logic              ic_resp_valid,
  output logic [LINE_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_data,
  output logic              dc_grant,
  output logic              dc_resp_valid,
  output logic [LINE_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_t;

  state_t              state_q;
  owner_t              owner_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                ic_grant_q;
  logic                dc_grant_q;
  logic                req_valid_q;
  logic                win_dc;
  logic                resp_fire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when DC owned the most recently completed transaction.
  logic                last_dc_q;
  // On a tie, the port that did not go last wins. A lone requester
  // always wins.
  assign win_dc = dc_req_valid && (!ic_req_valid || !last_dc_q);
`else
  assign win_dc = dc_req_valid;
`endif

  // Memory responses only count while waiting. Responses in IDLE or ISSUE
  // are stray traffic, and so is a response that arrives after a reset
  // aborted its transaction.
  assign resp_fire = (state_q == S_WAIT) && mem_resp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ic_grant_q  <= 1'b0;
      dc_grant_q  <= 1'b0;
      req_valid_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dc_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dc_req_valid || ic_req_valid) begin
            if (win_dc) begin
              owner_q    <= OWN_DC;
              rw_q       <= dc_req_rw;
              addr_q     <= dc_req_addr;
              // Fills carry no payload. Zero the payload so no stale
              // data leaks onto the bus.
              wdata_q    <= dc_req_rw ? dc_req_data : '0;
              dc_grant_q <= 1'b1;
            end else begin
              owner_q    <= OWN_IC;
              rw_q       <= 1'b0;
              addr_q     <= ic_req_addr;
              wdata_q    <= '0;
              ic_grant_q <= 1'b1;
            end
            req_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            // The grant stays high through the response cycle and
            // drops in the following IDLE cycle.
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            ic_grant_q <= 1'b0;
            dc_grant_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dc_q  <= (owner_q == OWN_DC);
`endif
          end
        end
        default: begin
          state_q     <= S_IDLE;
          owner_q     <= OWN_NONE;
          ic_grant_q  <= 1'b0;
          dc_grant_q  <= 1'b0;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ic_grant      = ic_grant_q;
  assign dc_grant      = dc_grant_q;

  assign mem_req_valid = req_valid_q;
  assign mem_req_rw    = rw_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = wdata_q;

  // The response is returned in the same cycle memory presents it.
  // IC only ever reads. A DC write ack returns zero data.
  assign ic_resp_valid = resp_fire && (owner_q == OWN_IC);
  assign ic_resp_data  = ic_resp_valid ? mem_resp_data : '0;
  assign dc_resp_valid = resp_fire && (owner_q == OWN_DC);
  assign dc_resp_data  = (dc_resp_valid && !rw_q) ? mem_resp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_grant;
  logic              ic_resp_valid;
  logic [LINE_W-1:0] ic_resp_data;
  logic              dc_req_valid;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [LINE_W-1:0] dc_req_data;
  logic              dc_grant;
  logic              dc_resp_valid;
  logic [LINE_W-1:0] dc_resp_data;
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_grant(ic_grant), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_grant(dc_grant), .dc_resp_valid(dc_resp_valid),
    .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                dc;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [LINE_W-1:0] GARBAGE = {4{32'hDEADBEEF}};

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input bit dc, input logic [LINE_W-1:0] data);
    exp_t e;
    e.dc   = dc;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input bit dc);
    check("ic_grant", {127'd0, ic_grant}, {127'd0, !dc});
    check("dc_grant", {127'd0, dc_grant}, {127'd0, dc});
  endtask

  // Response monitor: every resp pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    check("one_grant", {127'd0, ic_grant & dc_grant}, '0);
    if (ic_resp_valid || dc_resp_valid) begin
      check("resp_expected", {127'd0, sb.size() > 0}, 128'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("resp_port_dc", {127'd0, dc_resp_valid}, {127'd0, e.dc});
        check("resp_port_ic", {127'd0, ic_resp_valid}, {127'd0, !e.dc});
        check("resp_data", e.dc ? dc_resp_data : ic_resp_data, e.data);
        check("other_resp_data", e.dc ? ic_resp_data : dc_resp_data, '0);
      end
    end else begin
      check("idle_resp_data", ic_resp_data | dc_resp_data, '0);
    end
  end

  // Called in the arbitration cycle, after the request has been driven.
  // Walks the transaction through ISSUE, WAIT, the response cycle and the
  // following IDLE cycle.
  task automatic serve(input bit dc, input logic [ADDR_W-1:0] addr, input bit rw,
                       input logic [LINE_W-1:0] wdata, input int rdly, input int wdly,
                       input logic [LINE_W-1:0] rdata, input bit scramble,
                       input bit spur, input bit drop);
    for (int i = 0; i <= rdly; i++) begin
      cyc();
      mem_req_ready = (i == rdly);
      if (spur) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = GARBAGE;
      end
      if (scramble && i == 0) begin
        ic_req_addr = 32'hFFFF_FFF0;
        dc_req_addr = 32'hFFFF_FFF0;
        dc_req_rw   = ~dc_req_rw;
        dc_req_data = '1;
      end
      @(negedge clk);
      check("req_valid", {127'd0, mem_req_valid}, 128'd1);
      check("req_addr", {96'd0, mem_req_addr}, {96'd0, addr});
      check("req_rw", {127'd0, mem_req_rw}, {127'd0, rw});
      check("req_data", mem_req_data, wdata);
      check("issue_no_resp", {126'd0, ic_resp_valid, dc_resp_valid}, '0);
      chk_grant(dc);
    end
    for (int i = 0; i < wdly; i++) begin
      cyc();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (drop) begin
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
      end
      @(negedge clk);
      check("wait_req_valid", {127'd0, mem_req_valid}, '0);
      chk_grant(dc);
    end
    cyc();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    @(negedge clk);
    check("resp_pulse", {127'd0, dc ? dc_resp_valid : ic_resp_valid}, 128'd1);
    chk_grant(dc);
    cyc();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (dc) dc_req_valid = 1'b0;
    else    ic_req_valid = 1'b0;
    @(negedge clk);
    check("grant_drop_ic", {127'd0, ic_grant}, '0);
    check("grant_drop_dc", {127'd0, dc_grant}, '0);
    check("resp_one_cycle", {126'd0, ic_resp_valid, dc_resp_valid}, '0);
  endtask

  // Both ports request in the same IDLE cycle. The second port keeps its
  // request up and is served after the first.
  task automatic collide(input bit dc_first);
    logic [LINE_W-1:0] d_dat;
    logic [LINE_W-1:0] i_dat;
    d_dat = {4{32'hD0D0_0001}};
    i_dat = {4{32'h1C1C_0002}};
    cyc();
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h300;
    dc_req_valid = 1'b1;
    dc_req_rw    = 1'b0;
    dc_req_addr  = 32'h400;
    dc_req_data  = '1;
    if (dc_first) begin
      push(1'b1, d_dat);
      push(1'b0, i_dat);
    end else begin
      push(1'b0, i_dat);
      push(1'b1, d_dat);
    end
    @(negedge clk);
    check("tie_idle_req", {127'd0, mem_req_valid}, '0);
    if (dc_first) begin
      serve(1'b1, 32'h400, 1'b0, '0, 0, 1, d_dat, 1'b0, 1'b0, 1'b0);
      serve(1'b0, 32'h300, 1'b0, '0, 1, 0, i_dat, 1'b0, 1'b0, 1'b0);
    end else begin
      serve(1'b0, 32'h300, 1'b0, '0, 0, 1, i_dat, 1'b0, 1'b0, 1'b0);
      serve(1'b1, 32'h400, 1'b0, '0, 1, 0, d_dat, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    ic_req_valid   = 1'b0;
    ic_req_addr    = '0;
    dc_req_valid   = 1'b0;
    dc_req_rw      = 1'b0;
    dc_req_addr    = '0;
    dc_req_data    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (2) cyc();
    @(negedge clk);
    check("rst_ic_grant", {127'd0, ic_grant}, '0);
    check("rst_dc_grant", {127'd0, dc_grant}, '0);
    check("rst_req_valid", {127'd0, mem_req_valid}, '0);
    check("rst_req_addr", {96'd0, mem_req_addr}, '0);
    check("rst_req_data", mem_req_data, '0);
    check("rst_req_rw", {127'd0, mem_req_rw}, '0);
    cyc();
    reset = 1'b0;
    @(negedge clk);

    // IC read alone
    cyc();
    ic_req_valid  = 1'b1;
    ic_req_addr   = 32'h100;
    push(1'b0, {16{8'hA5}});
    @(negedge clk);
    check("t1_idle_req_valid", {127'd0, mem_req_valid}, '0);
    check("t1_idle_ic_grant", {127'd0, ic_grant}, '0);
    serve(1'b0, 32'h100, 1'b0, '0, 0, 2, {16{8'hA5}}, 1'b0, 1'b0, 1'b0);

    // Two collisions in a row: DC then IC each time
    collide(1'b1);
    collide(1'b1);

    // DC write-back with ready held low for two cycles; fields changed after latch
    cyc();
    dc_req_valid = 1'b1;
    dc_req_rw    = 1'b1;
    dc_req_addr  = 32'h2000;
    dc_req_data  = 128'h1234;
    push(1'b1, '0);
    @(negedge clk);
    serve(1'b1, 32'h2000, 1'b1, 128'h1234, 2, 1, {4{32'hFFFF0000}}, 1'b1, 1'b0, 1'b0);

    // A tie after a DC transaction: with alternation, IC goes first
`ifdef MEM_ARB_ROUND_ROBIN_EN
    collide(1'b0);
`else
    collide(1'b1);
`endif

    // Stray memory responses in IDLE and ISSUE
    cyc();
    mem_resp_valid = 1'b1;
    mem_resp_data  = GARBAGE;
    @(negedge clk);
    check("spur_idle_resp", {126'd0, ic_resp_valid, dc_resp_valid}, '0);
    check("spur_idle_req", {127'd0, mem_req_valid}, '0);
    cyc();
    mem_resp_valid = 1'b0;
    dc_req_valid   = 1'b1;
    dc_req_rw      = 1'b0;
    dc_req_addr    = 32'h800;
    push(1'b1, {4{32'h0808_0808}});
    @(negedge clk);
    serve(1'b1, 32'h800, 1'b0, '0, 1, 1, {4{32'h0808_0808}}, 1'b0, 1'b1, 1'b0);

    // Reset while waiting; the late response must be dropped
    cyc();
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h500;
    @(negedge clk);
    cyc();
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("rw_issue_valid", {127'd0, mem_req_valid}, 128'd1);
    cyc();
    mem_req_ready = 1'b0;
    reset         = 1'b1;
    ic_req_valid  = 1'b0;
    @(negedge clk);
    check("rw_wait_grant", {127'd0, ic_grant}, 128'd1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rw_ic_grant", {127'd0, ic_grant}, '0);
    check("rw_dc_grant", {127'd0, dc_grant}, '0);
    check("rw_req_valid", {127'd0, mem_req_valid}, '0);
    cyc();
    mem_resp_valid = 1'b1;
    mem_resp_data  = GARBAGE;
    @(negedge clk);
    check("rw_late_resp", {126'd0, ic_resp_valid, dc_resp_valid}, '0);
    cyc();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    ic_req_valid   = 1'b1;
    ic_req_addr    = 32'h600;
    push(1'b0, {4{32'h0606_0606}});
    @(negedge clk);
    serve(1'b0, 32'h600, 1'b0, '0, 0, 1, {4{32'h0606_0606}}, 1'b0, 1'b0, 1'b0);

    // Requester drops valid while waiting
    cyc();
    dc_req_valid = 1'b1;
    dc_req_rw    = 1'b0;
    dc_req_addr  = 32'h700;
    push(1'b1, {4{32'h0707_0707}});
    @(negedge clk);
    serve(1'b1, 32'h700, 1'b0, '0, 0, 2, {4{32'h0707_0707}}, 1'b0, 1'b0, 1'b1);

    repeat (3) cyc();
    @(negedge clk);
    check("sb_drained", 128'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
